// File: rtl/goose_anim_scheduler.sv
// goose_anim_scheduler
//
// Frame-rate animation scheduler for the goose sprite. Mode commands arrive
// over a valid/ready handshake, wait in a one-entry pending slot, and take
// effect only on a video frame boundary (frame_tick). Once a mode is active, a
// programmable frame divider steps the sprite frame index, x position, facing
// direction and honk enable.
//
// Ports:
//   clk         single clock
//   rst         synchronous, active-high reset
//   frame_tick  one-cycle pulse per video frame (start of vblank)
//   cmd_valid   command offered
//   cmd_ready   pending slot is empty, so a command can be accepted
//   cmd_mode    0 IDLE, 1 SPIN, 2 WALK, 3 HONK
//   cmd_div     frames per animation step, minus 1
//   anim_frame  sprite frame index to the renderer
//   goose_x     sprite left x
//   goose_dir   facing direction, 0 = right, 1 = left
//   honk_en     audio/beak enable, high throughout HONK
//   state       current mode, same encoding as cmd_mode
//   done        one-cycle pulse when a honk runs to completion
//
// Handshake: a command transfers on a clock edge where cmd_valid && cmd_ready.
// cmd_ready is simply "pending slot empty"; it drops the cycle after a
// transfer and rises again the cycle after the frame_tick that applies the
// pending command. cmd_valid may be held or dropped freely while cmd_ready=0.
module goose_anim_scheduler #(
    parameter int NUM_FRAMES = 8,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 576,
    parameter int STEP_PX    = 4,
    parameter int HONK_STEPS = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [3:0] cmd_div,
    output logic [2:0] anim_frame,
    output logic [9:0] goose_x,
    output logic       goose_dir,
    output logic       honk_en,
    output logic [1:0] state,
    output logic       done
);

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_SPIN = 2'd1,
        MODE_WALK = 2'd2,
        MODE_HONK = 2'd3
    } mode_t;

    localparam int            SW         = (HONK_STEPS < 2) ? 1 : $clog2(HONK_STEPS + 1);
    localparam logic [SW-1:0] HONK_LAST  = SW'(HONK_STEPS);
    localparam logic [2:0]    FRAME_MASK = 3'(NUM_FRAMES - 1);
    localparam logic [9:0]    X_MIN_V    = 10'(X_MIN);
    localparam logic [9:0]    X_MAX_V    = 10'(X_MAX);
    localparam logic [9:0]    STEP_V     = 10'(STEP_PX);

    mode_t         state_q, state_n;
    mode_t         pend_mode_q, pend_mode_n;
    logic          pend_q, pend_n;
    logic [3:0]    pend_div_q, pend_div_n;
    logic [3:0]    div_q, div_n;
    logic [3:0]    div_cnt_q, div_cnt_n;
    logic [SW-1:0] step_cnt_q, step_cnt_n;
    logic [2:0]    frame_q, frame_n;
    logic [9:0]    x_q, x_n;
    logic          dir_q, dir_n;
    logic          honk_q, honk_n;
    logic          done_q, done_n;
    logic          do_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MODE_IDLE;
            pend_q      <= 1'b0;
            pend_mode_q <= MODE_IDLE;
            pend_div_q  <= 4'd0;
            div_q       <= 4'd0;
            div_cnt_q   <= 4'd0;
            step_cnt_q  <= '0;
            frame_q     <= 3'd0;
            x_q         <= X_MIN_V;
            dir_q       <= 1'b0;
            honk_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            pend_q      <= pend_n;
            pend_mode_q <= pend_mode_n;
            pend_div_q  <= pend_div_n;
            div_q       <= div_n;
            div_cnt_q   <= div_cnt_n;
            step_cnt_q  <= step_cnt_n;
            frame_q     <= frame_n;
            x_q         <= x_n;
            dir_q       <= dir_n;
            honk_q      <= honk_n;
            done_q      <= done_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        pend_n      = pend_q;
        pend_mode_n = pend_mode_q;
        pend_div_n  = pend_div_q;
        div_n       = div_q;
        div_cnt_n   = div_cnt_q;
        step_cnt_n  = step_cnt_q;
        frame_n     = frame_q;
        x_n         = x_q;
        dir_n       = dir_q;
        done_n      = 1'b0;
        do_step     = 1'b0;

        // Accept only into an empty slot; apply only from a full slot, so the
        // two never happen in the same cycle and a command accepted on a tick
        // waits for the next tick.
        if (cmd_valid && !pend_q) begin
            pend_n      = 1'b1;
            pend_mode_n = mode_t'(cmd_mode);
            pend_div_n  = cmd_div;
        end

        if (frame_tick) begin
            if (pend_q) begin
                // Apply wins over any step, including a finishing honk step.
                state_n    = pend_mode_q;
                div_n      = pend_div_q;
                div_cnt_n  = 4'd0;
                step_cnt_n = '0;
                frame_n    = 3'd0;
                pend_n     = 1'b0;
            end else if (state_q != MODE_IDLE) begin
                if (div_cnt_q == div_q) begin
                    div_cnt_n = 4'd0;
                    do_step   = 1'b1;
                end else begin
                    div_cnt_n = div_cnt_q + 4'd1;
                end
            end
        end

        if (do_step) begin
            case (state_q)
                MODE_SPIN: frame_n = (frame_q + 3'd1) & FRAME_MASK;
                MODE_WALK: begin
                    frame_n = (frame_q == 3'd0) ? 3'd1 : 3'd0;
                    // 11-bit compares keep x+step and min+step from wrapping.
                    if (!dir_q) begin
                        if ({1'b0, x_q} + {1'b0, STEP_V} > {1'b0, X_MAX_V}) begin
                            x_n   = X_MAX_V;
                            dir_n = 1'b1;
                        end else begin
                            x_n = x_q + STEP_V;
                        end
                    end else begin
                        if ({1'b0, x_q} < {1'b0, X_MIN_V} + {1'b0, STEP_V}) begin
                            x_n   = X_MIN_V;
                            dir_n = 1'b0;
                        end else begin
                            x_n = x_q - STEP_V;
                        end
                    end
                end
                MODE_HONK: begin
                    step_cnt_n = step_cnt_q + SW'(1);
                    frame_n    = {2'b00, step_cnt_n[0]};
                    if (step_cnt_n == HONK_LAST) begin
                        state_n = MODE_IDLE;
                        frame_n = 3'd0;
                        done_n  = 1'b1;
                    end
                end
                default: frame_n = 3'd0;
            endcase
        end

        honk_n = (state_n == MODE_HONK);
    end

    assign cmd_ready  = !pend_q;
    assign state      = state_q;
    assign anim_frame = frame_q;
    assign goose_x    = x_q;
    assign goose_dir  = dir_q;
    assign honk_en    = honk_q;
    assign done       = done_q;

endmodule

// File: tb/tb_goose_anim_scheduler.sv
// Testbench for goose_anim_scheduler: directed scenarios from the feature list
// plus a randomized run, all checked against a behavioural model of the
// scheduler's rules kept in plain integers.
module tb_goose_anim_scheduler;

    localparam int NUM_FRAMES = 8;
    localparam int X_MIN      = 0;
    localparam int X_MAX      = 576;
    localparam int STEP_PX    = 4;
    localparam int HONK_STEPS = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_mode = 2'd0;
    logic [3:0] cmd_div = 4'd0;
    logic [2:0] anim_frame;
    logic [9:0] goose_x;
    logic       goose_dir;
    logic       honk_en;
    logic [1:0] state;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    goose_anim_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_div    (cmd_div),
        .anim_frame (anim_frame),
        .goose_x    (goose_x),
        .goose_dir  (goose_dir),
        .honk_en    (honk_en),
        .state      (state),
        .done       (done)
    );

    // Behavioural model: mode, counters and sprite attributes as integers.
    int m_state, m_frame, m_x, m_dir, m_honk, m_done;
    int m_pend, m_pmode, m_pdiv, m_div, m_cnt, m_steps;

    task automatic model_anim_step();
        case (m_state)
            1: m_frame = (m_frame + 1) % NUM_FRAMES;
            2: begin
                m_frame = 1 - m_frame;
                if (m_dir == 0) begin
                    if (m_x + STEP_PX > X_MAX) begin m_x = X_MAX; m_dir = 1; end
                    else m_x = m_x + STEP_PX;
                end else begin
                    if (m_x < X_MIN + STEP_PX) begin m_x = X_MIN; m_dir = 0; end
                    else m_x = m_x - STEP_PX;
                end
            end
            3: begin
                m_steps = m_steps + 1;
                m_frame = m_steps % 2;
                if (m_steps == HONK_STEPS) begin
                    m_state = 0;
                    m_frame = 0;
                    m_done  = 1;
                end
            end
            default: m_frame = 0;
        endcase
    endtask

    task automatic model_step(input bit r, input bit tick, input bit valid, input int mode, input int div);
        bit acc;
        if (r) begin
            m_state = 0; m_frame = 0; m_x = X_MIN; m_dir = 0; m_honk = 0; m_done = 0;
            m_pend = 0; m_pmode = 0; m_pdiv = 0; m_div = 0; m_cnt = 0; m_steps = 0;
            return;
        end
        m_done = 0;
        acc = valid && (m_pend == 0);
        if (tick && m_pend != 0) begin
            m_state = m_pmode; m_div = m_pdiv; m_cnt = 0; m_steps = 0; m_frame = 0; m_pend = 0;
        end else if (tick && m_state != 0) begin
            if (m_cnt == m_div) begin
                m_cnt = 0;
                model_anim_step();
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        if (acc) begin
            m_pend = 1; m_pmode = mode; m_pdiv = div;
        end
        m_honk = (m_state == 3) ? 1 : 0;
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge.
    task automatic cyc(input bit r, input bit tick, input bit valid, input int mode, input int div);
        rst        = r;
        frame_tick = tick;
        cmd_valid  = valid;
        cmd_mode   = 2'(mode);
        cmd_div    = 4'(div);
        model_step(r, tick, valid, mode, div);
        @(posedge clk);
        #1;
    endtask

    // Offer a command in an idle cycle, then apply it with a tick.
    task automatic send(input int mode, input int div);
        cyc(0, 0, 1, mode, div);
        cyc(0, 1, 0, 0, 0);
    endtask

    task automatic tick_gap();
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_tests++; if (anim_frame !== 3'd0) begin n_fail++; $display("FAIL reset_frame: got %0d expected 0", anim_frame); end
        n_tests++; if (goose_x !== 10'd0) begin n_fail++; $display("FAIL reset_x: got %0d expected 0", goose_x); end
        n_tests++; if (honk_en !== 1'b0 || done !== 1'b0 || goose_dir !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got honk=%0b done=%0b dir=%0b expected 0 0 0", honk_en, done, goose_dir); end
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", cmd_ready); end
        // Walk to x=300, park a pending command, then reset mid-operation.
        cyc(0, 0, 1, 2, 0);
        n_tests++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL accept_ready_low: got %0b expected 0", cmd_ready); end
        cyc(0, 1, 0, 0, 0);
        n_tests++; if (state !== 2'd2 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL walk_apply: got state=%0d ready=%0b expected 2 1", state, cmd_ready); end
        for (int k = 0; k < 75; k++) tick_gap();
        n_tests++; if (goose_x !== 10'd300) begin n_fail++; $display("FAIL walk_to_300: got %0d expected 300", goose_x); end
        cyc(0, 0, 1, 1, 0);
        cyc(1, 0, 0, 0, 0);
        n_tests++; if (state !== 2'd0 || goose_x !== 10'd0 || anim_frame !== 3'd0 || goose_dir !== 1'b0) begin n_fail++; $display("FAIL midrun_reset: got state=%0d x=%0d frame=%0d dir=%0b expected 0 0 0 0", state, goose_x, anim_frame, goose_dir); end
        n_tests++; if (cmd_ready !== 1'b1 || honk_en !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_ready: got ready=%0b honk=%0b done=%0b expected 1 0 0", cmd_ready, honk_en, done); end
        cyc(0, 1, 0, 0, 0);
        n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL pending_discarded: got state %0d expected 0", state); end
    endtask

    task automatic test_spin_wrap();
        send(1, 0);
        n_tests++; if (state !== 2'd1 || anim_frame !== 3'd0) begin n_fail++; $display("FAIL spin_apply: got state=%0d frame=%0d expected 1 0", state, anim_frame); end
        for (int k = 1; k <= 9; k++) begin
            cyc(0, 1, 0, 0, 0);
            n_tests++; if (anim_frame !== 3'(k % 8)) begin n_fail++; $display("FAIL spin_wrap_%0d: got %0d expected %0d", k, anim_frame, k % 8); end
            n_tests++; if (honk_en !== 1'b0) begin n_fail++; $display("FAIL spin_honk_%0d: got %0b expected 0", k, honk_en); end
            cyc(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_divider();
        send(1, 2);
        n_tests++; if (anim_frame !== 3'd0) begin n_fail++; $display("FAIL div_apply_frame: got %0d expected 0", anim_frame); end
        for (int k = 1; k <= 9; k++) begin
            tick_gap();
            n_tests++; if (anim_frame !== 3'(k / 3)) begin n_fail++; $display("FAIL divider_%0d: got %0d expected %0d", k, anim_frame, k / 3); end
        end
    endtask

    task automatic test_walk_bounce();
        int exp_x[5]   = '{572, 576, 576, 572, 568};
        int exp_dir[5] = '{0, 0, 1, 1, 1};
        send(2, 0);
        for (int k = 0; k < 142; k++) tick_gap();
        n_tests++; if (goose_x !== 10'd568 || goose_dir !== 1'b0) begin n_fail++; $display("FAIL walk_start: got x=%0d dir=%0b expected 568 0", goose_x, goose_dir); end
        for (int k = 0; k < 5; k++) begin
            tick_gap();
            n_tests++; if (goose_x !== 10'(exp_x[k])) begin n_fail++; $display("FAIL bounce_x_%0d: got %0d expected %0d", k, goose_x, exp_x[k]); end
            n_tests++; if (goose_dir !== 1'(exp_dir[k])) begin n_fail++; $display("FAIL bounce_dir_%0d: got %0b expected %0d", k, goose_dir, exp_dir[k]); end
            n_tests++; if (anim_frame !== 3'((k + 1) % 2)) begin n_fail++; $display("FAIL bounce_frame_%0d: got %0d expected %0d", k, anim_frame, (k + 1) % 2); end
        end
    endtask

    task automatic test_honk_done();
        send(3, 0);
        n_tests++; if (honk_en !== 1'b1 || state !== 2'd3) begin n_fail++; $display("FAIL honk_apply: got honk=%0b state=%0d expected 1 3", honk_en, state); end
        for (int k = 1; k <= HONK_STEPS; k++) begin
            cyc(0, 1, 0, 0, 0);
            if (k < HONK_STEPS) begin
                n_tests++; if (honk_en !== 1'b1 || done !== 1'b0 || state !== 2'd3) begin n_fail++; $display("FAIL honk_step_%0d: got honk=%0b done=%0b state=%0d expected 1 0 3", k, honk_en, done, state); end
                n_tests++; if (anim_frame !== 3'(k % 2)) begin n_fail++; $display("FAIL honk_beak_%0d: got %0d expected %0d", k, anim_frame, k % 2); end
            end else begin
                n_tests++; if (done !== 1'b1 || honk_en !== 1'b0) begin n_fail++; $display("FAIL honk_done: got done=%0b honk=%0b expected 1 0", done, honk_en); end
                n_tests++; if (state !== 2'd0 || anim_frame !== 3'd0) begin n_fail++; $display("FAIL honk_to_idle: got state=%0d frame=%0d expected 0 0", state, anim_frame); end
            end
            cyc(0, 0, 0, 0, 0);
            n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle_%0d: got %0b expected 0", k, done); end
        end
        tick_gap();
        n_tests++; if (state !== 2'd0 || anim_frame !== 3'd0) begin n_fail++; $display("FAIL idle_frozen: got state=%0d frame=%0d expected 0 0", state, anim_frame); end
    endtask

    task automatic test_cmd_on_tick();
        cyc(0, 1, 1, 1, 0);
        n_tests++; if (cmd_ready !== 1'b0 || state !== 2'd0) begin n_fail++; $display("FAIL cmd_on_tick: got ready=%0b state=%0d expected 0 0", cmd_ready, state); end
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 0);
            n_tests++; if (cmd_ready !== 1'b0 || state !== 2'd0) begin n_fail++; $display("FAIL cmd_waiting_%0d: got ready=%0b state=%0d expected 0 0", k, cmd_ready, state); end
        end
        cyc(0, 1, 0, 0, 0);
        n_tests++; if (state !== 2'd1 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cmd_next_tick: got state=%0d ready=%0b expected 1 1", state, cmd_ready); end
    endtask

    task automatic test_honk_abort();
        send(3, 0);
        for (int k = 0; k < HONK_STEPS - 1; k++) tick_gap();
        cyc(0, 0, 1, 1, 0);
        cyc(0, 1, 0, 0, 0);
        n_tests++; if (state !== 2'd1 || done !== 1'b0) begin n_fail++; $display("FAIL honk_abort: got state=%0d done=%0b expected 1 0", state, done); end
        n_tests++; if (honk_en !== 1'b0 || anim_frame !== 3'd0) begin n_fail++; $display("FAIL honk_abort_out: got honk=%0b frame=%0d expected 0 0", honk_en, anim_frame); end
        cyc(0, 0, 0, 0, 0);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL honk_abort_nodone: got %0b expected 0", done); end
    endtask

    task automatic test_random();
        int shown = 0;
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            n_tests++;
            if (state !== 2'(m_state) || anim_frame !== 3'(m_frame) || goose_x !== 10'(m_x) ||
                goose_dir !== 1'(m_dir) || honk_en !== 1'(m_honk) || done !== 1'(m_done) ||
                cmd_ready !== 1'(m_pend == 0)) begin
                n_fail++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL random_%0d: got st=%0d fr=%0d x=%0d dir=%0b honk=%0b done=%0b rdy=%0b expected %0d %0d %0d %0d %0d %0d %0d",
                             i, state, anim_frame, goose_x, goose_dir, honk_en, done, cmd_ready,
                             m_state, m_frame, m_x, m_dir, m_honk, m_done, (m_pend == 0));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_spin_wrap();
        test_divider();
        test_walk_bounce();
        test_honk_done();
        test_cmd_on_tick();
        test_honk_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/goose_anim_scheduler.md
# goose_anim_scheduler

Frame-rate animation scheduler for the goose sprite. It takes mode commands from the top-level input decode over a valid/ready handshake and applies them only on video frame boundaries. It then steps the sprite renderer's animation frame index, horizontal position, facing direction and honk enable once per programmable number of video frames. It sits between the `ui_in` command decode and the sprite/VGA datapath in `tt_um_goose`.

## Interface
Parameters:
- `NUM_FRAMES`, default 8: frames in the spin cycle; must be a power of two, at most 8.
- `X_MIN`, default 0: leftmost sprite x.
- `X_MAX`, default 576: rightmost sprite x (640 − 64).
- `STEP_PX`, default 4: pixels moved per walk step.
- `HONK_STEPS`, default 6: animation steps a honk lasts.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse once per video frame, at the start of vblank.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: scheduler can accept a command.
- `cmd_mode` in 2: 0 IDLE, 1 SPIN, 2 WALK, 3 HONK.
- `cmd_div` in 4: frames per animation step, minus 1.
- `anim_frame` out 3: sprite frame index to the renderer.
- `goose_x` out 10: sprite left x.
- `goose_dir` out 1: facing direction; 0 = right, 1 = left.
- `honk_en` out 1: audio/beak enable.
- `state` out 2: current mode, same encoding as `cmd_mode`.
- `done` out 1: one-cycle pulse when a honk completes naturally.

## Operation
- **Reset values:**
  - `state`=IDLE, `anim_frame`=0, `goose_x`=X_MIN, `goose_dir`=0.
  - `honk_en`=0, `done`=0.
  - `cmd_ready`=1, pending slot empty, div=0, div_cnt=0, step_cnt=0.
- **Handshake:**
  - `cmd_ready` = pending slot empty.
  - Accept on `cmd_valid && cmd_ready`; latch mode and div into the pending slot.
  - `cmd_ready` falls the next cycle.
- **Apply:**
  - On a `frame_tick` with the pending slot full, load state and div from the slot.
  - Clear div_cnt, step_cnt and `anim_frame`; empty the slot.
  - `goose_x` and `goose_dir` are preserved.
  - No animation step occurs on an apply tick.
- **Divider:** on a `frame_tick` with no pending command and state ≠ IDLE:
  - If div_cnt == div, do one step and set div_cnt to 0.
  - Otherwise increment div_cnt.
- **SPIN step:** `anim_frame` increments modulo NUM_FRAMES; 7 wraps to 0 at the default.
- **WALK step:**
  - `anim_frame` toggles between 0 and 1.
  - Right (dir=0): if `goose_x` + STEP_PX > X_MAX, set x to X_MAX and dir to 1; else x += STEP_PX.
  - Left: if `goose_x` < X_MIN + STEP_PX, set x to X_MIN and dir to 0; else x −= STEP_PX.
  - Compare at 11 bits so there is no wrap-around.
- **HONK:**
  - `honk_en`=1 throughout the HONK state.
  - Each step: step_cnt += 1 and `anim_frame` = step_cnt[0] (beak open/closed).
  - On the step where step_cnt reaches HONK_STEPS: state becomes IDLE, `honk_en` becomes 0 and `done` pulses for one cycle.
- **IDLE:** `anim_frame` forced to 0; x and dir held; divider frozen.

## Timing
- All outputs are registered and change in the cycle after the qualifying `frame_tick` edge.
- Apply latency: a command accepted in cycle N takes effect at the first `frame_tick` in a cycle > N.
  - A command accepted in the same cycle as `frame_tick` waits for the following tick.
  - `cmd_ready` returns to 1 in the cycle after the apply tick.
- Step period: (div+1) frame_ticks. The first step comes div+1 ticks after the apply tick.
- **Simultaneous events:**
  - A pending apply on the tick that would finish a honk wins: the honk is aborted and there is no `done` pulse.
  - A HONK command applied while in HONK restarts step_cnt.
- **Mid-operation reset:** `rst` overrides everything in the same edge; a pending command is discarded.
- `frame_tick` held high for several cycles counts as one event per cycle. Upstream guarantees single-cycle pulses; the scheduler does not edge-detect.

## Test plan
- **Reset:** assert `rst` during WALK with x=300 → all outputs at reset values the next cycle; `cmd_ready`=1.
- **SPIN wrap:** SPIN, div=0, then 9 ticks after apply → `anim_frame` 1,2,…,7,0,1; `honk_en`=0.
- **Divider:** SPIN, div=2 → `anim_frame` advances only on every 3rd tick after apply.
- **WALK bounce:** WALK, div=0, start x=568 → x steps 572, 576 with dir 0, then 576 with dir=1, then 572, 568; `anim_frame` alternates 0/1.
- **HONK done:** HONK, div=0 → `honk_en`=1 for 6 steps; `done` pulses once on the 6th step; state returns to IDLE with `anim_frame`=0.
- **Handshake/collision:**
  - Offer a cmd in the same cycle as `frame_tick` → not applied until the next tick; `cmd_ready`=0 for that interval.
  - A SPIN command pending on the final honk step → state becomes SPIN with no `done` pulse.
